// File: rtl/matmul_pkg.sv
// Shared types and helpers for the 4x4 matrix-multiply stream controller.
package matmul_pkg;

    function automatic int unsigned out_width(input int unsigned w);
        return 2 * w + 2;
    endfunction

    localparam int unsigned W_DEF    = 8;
    localparam int unsigned WOUT_DEF = out_width(W_DEF);

    typedef logic signed [W_DEF-1:0]    mat_in_t  [4][4];
    typedef logic signed [WOUT_DEF-1:0] mat_out_t [4][4];

    typedef enum logic {IDLE, COMPUTE} cstate_t;

endpackage

// File: rtl/matmul4x4_stream_ctrl_mult.sv
// Combinational signed 4x4 matrix product C = A*B over flattened row-major buses.
module matrix_mult_4x4_alphaevolve_dumas #(
    parameter int unsigned w         = 8,
    parameter int unsigned WIDTH_OUT = 2 * w + 2
) (
    input  logic [16*w-1:0]         A,
    input  logic [16*w-1:0]         B,
    output logic [16*WIDTH_OUT-1:0] C
);

    always_comb begin
        logic signed [WIDTH_OUT-1:0] acc;
        logic signed [w-1:0]         ea;
        logic signed [w-1:0]         eb;
        logic signed [2*w-1:0]       p;
        C   = '0;
        acc = '0;
        ea  = '0;
        eb  = '0;
        p   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = 0; j < 4; j++) begin
                acc = '0;
                for (int unsigned k = 0; k < 4; k++) begin
                    ea  = A[(4*i+k)*w +: w];
                    eb  = B[(4*k+j)*w +: w];
                    p   = (2*w)'(ea) * (2*w)'(eb);
                    acc = acc + WIDTH_OUT'(p);
                end
                C[(4*i+j)*WIDTH_OUT +: WIDTH_OUT] = acc;
            end
        end
    end

endmodule

// File: rtl/matmul4x4_stream_ctrl.sv
// Streams A/B operands in, holds them for a multicycle compute window around the
// 4x4 multiplier, then streams C out row-major while the next job loads.
module matmul4x4_stream_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned w              = 8,
    parameter int unsigned WIDTH_OUT      = out_width(w),
    parameter int unsigned COMPUTE_CYCLES = 1,
    parameter int unsigned JOB_CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [w-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic [JOB_CNT_W-1:0] job_count
);

    cstate_t state, state_nxt;

    logic                 clr;
    logic [4:0]           ld_idx;
    logic                 ld_full, res_full;
    logic [3:0]           cnt;
    logic [3:0]           o_idx;
    logic [w-1:0]         a_reg [16];
    logic [w-1:0]         b_reg [16];
    logic [WIDTH_OUT-1:0] res   [16];
    logic [WIDTH_OUT-1:0] out_q;
    logic [JOB_CNT_W-1:0] jobs;

    logic [16*w-1:0]         a_flat, b_flat;
    logic [16*WIDTH_OUT-1:0] c_flat;

    logic accept, ld_done, out_hs, drain_done, last_cmp;
    logic ld_full_nxt, res_full_nxt;

    assign clr = rst | flush;

    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            a_flat[i*w +: w] = a_reg[i];
            b_flat[i*w +: w] = b_reg[i];
        end
    end

    matrix_mult_4x4_alphaevolve_dumas #(
        .w         (w),
        .WIDTH_OUT (WIDTH_OUT)
    ) u_mult (
        .A (a_flat),
        .B (b_flat),
        .C (c_flat)
    );

    // COMPUTE is entered on the same edge that completes the load (or frees the
    // result register), so a 1-cycle budget yields out_valid two cycles after the
    // last accept.
    always_comb begin
        accept       = in_valid && !ld_full;
        ld_done      = accept && (ld_idx == 5'd31);
        out_hs       = res_full && out_ready;
        drain_done   = out_hs && (o_idx == 4'd15);
        last_cmp     = (state == COMPUTE) && (cnt == 4'(COMPUTE_CYCLES - 1));
        ld_full_nxt  = (ld_full && !last_cmp) || ld_done;
        res_full_nxt = (res_full && !drain_done) || last_cmp;
        state_nxt    = state;
        unique case (state)
            IDLE:    if (ld_full_nxt && !res_full_nxt) state_nxt = COMPUTE;
            COMPUTE: if (last_cmp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ld_idx   <= '0;
            ld_full  <= 1'b0;
            res_full <= 1'b0;
            cnt      <= '0;
            o_idx    <= '0;
            out_q    <= '0;
            jobs     <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
                res[i]   <= '0;
            end
        end else begin
            if (accept) begin
                if (!ld_idx[4]) a_reg[ld_idx[3:0]] <= in_data;
                else            b_reg[ld_idx[3:0]] <= in_data;
                ld_idx <= ld_idx + 5'd1;
            end
            ld_full  <= ld_full_nxt;
            res_full <= res_full_nxt;

            if (state == IDLE && state_nxt == COMPUTE) cnt <= '0;
            else if (state == COMPUTE)                 cnt <= cnt + 4'd1;

            if (last_cmp) begin
                for (int unsigned i = 0; i < 16; i++)
                    res[i] <= c_flat[i*WIDTH_OUT +: WIDTH_OUT];
                out_q <= c_flat[0 +: WIDTH_OUT];
                jobs  <= jobs + 1'b1;
            end

            if (out_hs) begin
                o_idx <= o_idx + 4'd1;
                out_q <= res[o_idx + 4'd1];
            end
        end
    end

    assign in_ready  = !ld_full;
    assign out_valid = res_full;
    assign out_data  = out_q;
    assign out_last  = (o_idx == 4'd15);
    assign busy      = ld_full | (state == COMPUTE) | res_full;
    assign job_count = jobs;

endmodule

// File: tb/tb_matmul4x4_stream_ctrl.sv
// Scoreboard bench for matmul4x4_stream_ctrl: two instances (1- and 3-cycle compute)
// share stimulus, selected by sel; a negedge monitor pops and checks every handshake.
module tb_matmul4x4_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, sel;
    logic [7:0]  in_data;
    logic        rdy0, rdy1, ov0, ov1, ol0, ol1, bsy0, bsy1;
    logic [17:0] od0, od1;
    logic [15:0] jc0, jc1;
    logic        rdy, ov, ol, bsy;
    logic [17:0] od;
    logic [15:0] jc;

    assign rdy = sel ? rdy1 : rdy0;
    assign ov  = sel ? ov1  : ov0;
    assign ol  = sel ? ol1  : ol0;
    assign bsy = sel ? bsy1 : bsy0;
    assign od  = sel ? od1  : od0;
    assign jc  = sel ? jc1  : jc0;

    matmul4x4_stream_ctrl #(.w(8), .WIDTH_OUT(18), .COMPUTE_CYCLES(1), .JOB_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid && !sel), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_last(ol0),
        .busy(bsy0), .job_count(jc0)
    );

    matmul4x4_stream_ctrl #(.w(8), .WIDTH_OUT(18), .COMPUTE_CYCLES(3), .JOB_CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid && sel), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_last(ol1),
        .busy(bsy1), .job_count(jc1)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          nvec = 0;
    int          nerr = 0;
    int          or_mode = 1;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_od = '0;
    int          a[16], b[16], a1[16], b1[16], a2[16], b2[16], a3[16], b3[16];
    int          n, t2;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // out_ready only changes just after posedge so the monitor sees a settled value
    initial forever begin
        @(posedge clk);
        #1;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rst || flush) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ov) chk("hold_stable", od, prev_od);
            if (ov && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", $signed(od), e.data);
                    chk("out_last", ol, e.last);
                end
            end
            prev_stall = ov && !out_ready;
            prev_od    = od;
        end
    end

    task automatic send_elem(input int d);
        int t;
        t = 0;
        in_data  = 8'(d);
        in_valid = 1'b1;
        while (!rdy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_job(input int ma[16], input int mb[16]);
        for (int k = 0; k < 32; k++) send_elem(k < 16 ? ma[k] : mb[k-16]);
    endtask

    task automatic push_golden(input int ma[16], input int mb[16]);
        int s;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += ma[4*i+k] * mb[4*k+j];
                q.push_back('{s, (i == 3 && j == 3)});
            end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || ov) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("drain_timeout", 0, 1);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_in_ready"}, rdy, 1);
        chk({tag, "_out_valid"}, ov, 0);
        chk({tag, "_out_data"}, od, 0);
        chk({tag, "_out_last"}, ol, 0);
        chk({tag, "_busy"}, bsy, 0);
        chk({tag, "_job_count"}, jc, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk_rst(tag);
    endtask

    task automatic rand_mat(output int m[16]);
        for (int k = 0; k < 16; k++) m[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        sel = 1'b0; out_ready = 1'b1; or_mode = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_rst("reset");

        // identity x ramp: C = B, first result two cycles after last accept
        for (int k = 0; k < 16; k++) begin
            a[k] = (k / 4 == k % 4) ? 1 : 0;
            b[k] = k;
            q.push_back('{k, (k == 15)});
        end
        send_job(a, b);
        n = 1;
        while (!ov && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency_cc1", n, 2);
        chk("in_ready_back_cc1", rdy, 1);
        wait_drain();
        chk("job_count_identity", jc, 1);

        for (int k = 0; k < 16; k++) begin
            a[k] = -128; b[k] = -128;
            q.push_back('{65536, (k == 15)});
        end
        send_job(a, b);
        wait_drain();
        for (int k = 0; k < 16; k++) begin
            a[k] = 127; b[k] = -128;
            q.push_back('{-65024, (k == 15)});
        end
        send_job(a, b);
        wait_drain();
        chk("job_count_extremes", jc, 3);

        // random operands with a randomly throttled sink
        or_mode = 2;
        for (int r = 0; r < 3; r++) begin
            rand_mat(a);
            rand_mat(b);
            push_golden(a, b);
            send_job(a, b);
        end
        wait_drain();
        or_mode = 1;
        repeat (2) @(negedge clk);
        chk("job_count_random", jc, 6);

        // three jobs back to back behind a stalled sink
        do_reset("reset2");
        or_mode = 0;
        rand_mat(a1); rand_mat(b1); rand_mat(a2); rand_mat(b2); rand_mat(a3); rand_mat(b3);
        push_golden(a1, b1);
        push_golden(a2, b2);
        push_golden(a3, b3);
        fork
            begin
                send_job(a1, b1);
                send_job(a2, b2);
                chk("in_ready_drop_job2", rdy, 0);
                send_job(a3, b3);
            end
            begin
                t2 = 0;
                while (!ov && t2 < 500) begin
                    @(negedge clk);
                    t2++;
                end
                repeat (40) @(negedge clk);
                chk("stall_job_count", jc, 1);
                chk("stall_in_ready", rdy, 0);
                chk("stall_busy", bsy, 1);
                or_mode = 1;
            end
        join
        wait_drain();
        chk("job_count_b2b", jc, 3);

        // aborted partial load, then flush mid-drain
        for (int k = 0; k < 10; k++) send_elem(100 - k);
        do_reset("rst_partial");
        rand_mat(a); rand_mat(b);
        push_golden(a, b);
        send_job(a, b);
        t2 = 0;
        while (!ov && t2 < 50) begin
            @(negedge clk);
            t2++;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        q.delete();
        @(negedge clk);
        chk_rst("flush");
        rand_mat(a); rand_mat(b);
        push_golden(a, b);
        send_job(a, b);
        wait_drain();
        chk("job_count_after_flush", jc, 1);

        // 3-cycle compute instance
        sel = 1'b1;
        do_reset("reset_cc3");
        for (int k = 0; k < 16; k++) begin
            a[k] = (k / 4 == k % 4) ? 1 : 0;
            b[k] = k;
            q.push_back('{k, (k == 15)});
        end
        send_job(a, b);
        n = 1;
        while (!ov && n < 50) begin
            if (n == 2) chk("cc3_in_ready_during_compute", rdy, 0);
            @(negedge clk);
            n++;
        end
        chk("latency_cc3", n, 4);
        chk("in_ready_back_cc3", rdy, 1);
        wait_drain();
        chk("job_count_cc3", jc, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
